ps2_key_sequencer: RTL

PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

---
 rtl/ps2_key_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into key events queued in a FWFT FIFO.
// Optional build macro PS2_SEQ_TYPEMATIC_FILTER_EN suppresses repeated makes of a held key.
module ps2_key_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_parity_err,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       overflow,
    output logic [7:0] err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [TW-1:0]  tmo_cnt;

    logic           is_e0;
    logic           is_f0;
    logic           is_status;
    logic           dec_emit;
    logic           dec_brk;
    logic           dec_ext;
    logic           suppress;
    logic           push;

    logic [9:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           pop;
    logic           do_push;
    logic [9:0]     head;

    assign is_e0 = (rx_byte == PFX_EXT);
    assign is_f0 = (rx_byte == PFX_BRK);

    always_comb begin
        is_status = 1'b0;
        case (rx_byte)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_status = 1'b1;
            default: is_status = 1'b0;
        endcase
    end

    // Next state and event for the byte on rx_byte; only consumed when rx_valid is high.
    always_comb begin
        next_state = IDLE;
        dec_emit   = 1'b0;
        dec_brk    = 1'b0;
        dec_ext    = 1'b0;
        if (!rx_parity_err && !is_status) begin
            case (state)
                IDLE: begin
                    if (is_e0)      next_state = GOT_E0;
                    else if (is_f0) next_state = GOT_F0;
                    else            dec_emit   = 1'b1;
                end
                GOT_E0: begin
                    if (is_f0)      next_state = GOT_E0F0;
                    else if (is_e0) next_state = GOT_E0;
                    else begin
                        dec_emit = 1'b1;
                        dec_ext  = 1'b1;
                    end
                end
                GOT_F0: begin
                    if (!is_e0 && !is_f0) begin
                        dec_emit = 1'b1;
                        dec_brk  = 1'b1;
                    end
                end
                GOT_E0F0: begin
                    if (!is_e0 && !is_f0) begin
                        dec_emit = 1'b1;
                        dec_brk  = 1'b1;
                        dec_ext  = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

`ifdef PS2_SEQ_TYPEMATIC_FILTER_EN
    logic       filt_valid;
    logic [7:0] filt_code;
    logic       filt_ext;
    logic       filt_hit;

    assign filt_hit = filt_valid && (filt_code == rx_byte) && (filt_ext == dec_ext);
    assign suppress = filt_hit && !dec_brk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_valid <= 1'b0;
            filt_code  <= 8'h00;
            filt_ext   <= 1'b0;
        end else if (rx_valid && dec_emit) begin
            if (!dec_brk) begin
                filt_valid <= 1'b1;
                filt_code  <= rx_byte;
                filt_ext   <= dec_ext;
            end else if (filt_hit) begin
                filt_valid <= 1'b0;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign push = rx_valid && dec_emit && !suppress;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            err_count <= 8'h00;
        end else begin
            if (rx_valid) begin
                state   <= next_state;
                tmo_cnt <= '0;
                if (rx_parity_err && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end else if (state != IDLE) begin
                if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state   <= IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = ev_valid && ev_ready;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= {rx_byte, dec_brk, dec_ext};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !do_push)
                overflow <= 1'b1;
        end
    end

    assign head     = mem[rd_ptr];
    assign ev_valid = (count != '0);
    assign ev_code  = ev_valid ? head[9:2] : 8'h00;
    assign ev_break = ev_valid ? head[1] : 1'b0;
    assign ev_ext   = ev_valid ? head[0] : 1'b0;

endmodule
